// File: rtl/beam_accum.sv
// beam_accum: sums NUM_CH consecutive multiplier products into one beam sample,
// scales it by OUT_SHIFT and holds it on a valid/ready output until it is taken.
// Optional feature macro: BEAM_ACCUM_SAT_EN (accumulator saturates instead of wrapping).
module beam_accum #(
    parameter int NUM_CH    = 8,
    parameter int PROD_W    = 32,
    parameter int ACC_W     = 35,
    parameter int OUT_SHIFT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod_data,
    input  logic              prod_first,
    output logic              prod_ready,
    output logic              beam_valid,
    output logic [ACC_W-1:0]  beam_data,
    output logic              beam_ovf,
    input  logic              beam_ready,
    output logic              sync_err
);

    localparam int CW = $clog2(NUM_CH);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CH - 1);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               beam_valid_q, beam_valid_d;
    logic [ACC_W-1:0]   beam_data_q, beam_data_d;
    logic               beam_ovf_q, beam_ovf_d;
    logic               sync_err_q, sync_err_d;

    logic               accept;
    logic               restart;
    logic [ACC_W-1:0]   base;
    logic [ACC_W:0]     sum;
    logic               ovf_nxt;
    logic [ACC_W-1:0]   result;
    logic [CW-1:0]      idx;

    assign prod_ready = (state_q == ST_ACC) && rst_n;
    assign accept     = prod_valid && prod_ready;

    // Datapath for the current product: a fresh beam (first flag or count 0)
    // starts from zero, discarding any partial sum.
    always_comb begin
        restart = prod_first || (cnt_q == '0);
        base    = restart ? '0 : acc_q;
        sum     = {1'b0, base} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_data};
        ovf_nxt = ((base == '0) ? 1'b0 : ovf_q) | sum[ACC_W];
`ifdef BEAM_ACCUM_SAT_EN
        // Once overflowed, the beam is pinned at full scale until it completes.
        result  = ovf_nxt ? '1 : sum[ACC_W-1:0];
`else
        result  = sum[ACC_W-1:0];
`endif
        idx     = restart ? '0 : cnt_q;
    end

    // Next-state and register update logic for both states.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        beam_valid_d = beam_valid_q;
        beam_data_d  = beam_data_q;
        beam_ovf_d   = beam_ovf_q;
        sync_err_d   = sync_err_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (prod_first && (cnt_q != '0))
                        sync_err_d = 1'b1;
                    if (idx == LAST_IDX) begin
                        beam_data_d  = result >> OUT_SHIFT;
                        beam_ovf_d   = ovf_nxt;
                        beam_valid_d = 1'b1;
                        cnt_d        = '0;
                        acc_d        = '0;
                        ovf_d        = 1'b0;
                        state_d      = ST_OUT;
                    end else begin
                        acc_d = result;
                        cnt_d = idx + 1'b1;
                        ovf_d = ovf_nxt;
                    end
                end
            end
            ST_OUT: begin
                if (beam_valid_q && beam_ready) begin
                    beam_valid_d = 1'b0;
                    state_d      = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_ACC;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            beam_valid_q <= 1'b0;
            beam_data_q  <= '0;
            beam_ovf_q   <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            beam_valid_q <= beam_valid_d;
            beam_data_q  <= beam_data_d;
            beam_ovf_q   <= beam_ovf_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign beam_valid = beam_valid_q;
    assign beam_data  = beam_data_q;
    assign beam_ovf   = beam_ovf_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_beam_accum.sv
// Bench for beam_accum: three instances (default, ACC_W=33, OUT_SHIFT=3) share
// one stimulus stream; a scoreboard queue holds expected beams per transfer.
module tb_beam_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        prod_valid;
    logic [31:0] prod_data;
    logic        prod_first;
    logic        beam_ready;

    logic        pr0, pr1, pr2, bv0, bv1, bv2, bo0, bo1, bo2, se0, se1, se2;
    logic [34:0] bd0, bd2;
    logic [32:0] bd1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    beam_accum u_def (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_first(prod_first), .prod_ready(pr0), .beam_valid(bv0), .beam_data(bd0),
        .beam_ovf(bo0), .beam_ready(beam_ready), .sync_err(se0));

    beam_accum #(.ACC_W(33)) u_a33 (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_first(prod_first), .prod_ready(pr1), .beam_valid(bv1), .beam_data(bd1),
        .beam_ovf(bo1), .beam_ready(beam_ready), .sync_err(se1));

    beam_accum #(.OUT_SHIFT(3)) u_sh3 (
        .clk(clk), .rst_n(rst_n), .prod_valid(prod_valid), .prod_data(prod_data),
        .prod_first(prod_first), .prod_ready(pr2), .beam_valid(bv2), .beam_data(bd2),
        .beam_ovf(bo2), .beam_ready(beam_ready), .sync_err(se2));

    typedef struct {
        logic [34:0] d0;
        logic        o0;
        logic [32:0] d1;
        logic        o1;
        logic [34:0] d2;
    } exp_t;

    typedef struct {
        logic [31:0] v;
        exp_t        e;
    } vec_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare every accepted beam against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bv0 && beam_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_beam: got data %0h expected no beam", bd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beam_data_def", 64'(bd0), 64'(e.d0));
                chk("beam_ovf_def",  64'(bo0), 64'(e.o0));
                chk("beam_data_a33", 64'(bd1), 64'(e.d1));
                chk("beam_ovf_a33",  64'(bo1), 64'(e.o1));
                chk("beam_data_sh3", 64'(bd2), 64'(e.d2));
                chk("beam_ovf_sh3",  64'(bo2), 64'(e.o0));
                chk("beam_valid_lockstep", 64'({bv1, bv2}), 64'(2'b11));
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic f);
        int t = 0;
        prod_valid = 1'b1;
        prod_data  = d;
        prod_first = f;
        while (!(pr0 && pr1 && pr2) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got prod_ready 0 expected 1");
        end
        @(posedge clk); #1;
        prod_valid = 1'b0;
        prod_first = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    vec_t vecs[5];

    initial begin
        int vcnt;
        exp_t e;
`ifdef BEAM_ACCUM_SAT_EN
        vecs[0] = '{32'hFFFE0001, '{35'h7FFF00008, 1'b0, 33'h1FFFFFFFF, 1'b1, 35'h0FFFE0001}};
        vecs[4] = '{32'hFFFFFFFF, '{35'h7FFFFFFF8, 1'b0, 33'h1FFFFFFFF, 1'b1, 35'h0FFFFFFFF}};
`else
        vecs[0] = '{32'hFFFE0001, '{35'h7FFF00008, 1'b0, 33'h1FFF00008, 1'b1, 35'h0FFFE0001}};
        vecs[4] = '{32'hFFFFFFFF, '{35'h7FFFFFFF8, 1'b0, 33'h1FFFFFFF8, 1'b1, 35'h0FFFFFFFF}};
`endif
        vecs[1] = '{32'h1,   '{35'h8,   1'b0, 33'h8,   1'b0, 35'h1}};
        vecs[2] = '{32'h107, '{35'h838, 1'b0, 33'h838, 1'b0, 35'h107}};
        vecs[3] = '{32'h0,   '{35'h0,   1'b0, 33'h0,   1'b0, 35'h0}};

        rst_n = 1'b0; prod_valid = 1'b0; prod_data = '0; prod_first = 1'b0; beam_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_prod_ready", 64'(pr0), 64'd0);
        chk("rst_outputs", 64'({bv0, bo0, se0, bd0}), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("prod_ready_after_rst", 64'({pr0, pr1, pr2}), 64'(3'b111));

        // Table: 8 identical products per beam at full rate, beam_ready held high.
        foreach (vecs[i]) begin
            sb.push_back(vecs[i].e);
            for (int k = 0; k < 8; k++) send(vecs[i].v, k == 0);
            vcnt = 0;
            repeat (4) begin
                @(negedge clk);
                if (bv0) vcnt++;
            end
            chk("beam_valid_one_cycle", 64'(vcnt), 64'd1);
            drain("drain_table");
            @(posedge clk); #1;
        end
        chk("sync_err_clean", 64'({se0, se1, se2}), 64'd0);

        // Backpressure: 1..8 held for six cycles, no products accepted meanwhile.
        beam_ready = 1'b0;
        sb.push_back('{35'd36, 1'b0, 33'd36, 1'b0, 35'd4});
        for (int k = 1; k <= 8; k++) send(32'(k), k == 1);
        repeat (5) begin
            chk("bp_valid", 64'(bv0), 64'd1);
            chk("bp_data_held", 64'(bd0), 64'd36);
            chk("bp_prod_ready", 64'(pr0), 64'd0);
            @(posedge clk); #1;
        end
        beam_ready = 1'b1;
        chk("bp_data_last", 64'(bd0), 64'd36);
        chk("bp_prod_ready_last", 64'(pr0), 64'd0);
        @(posedge clk); #1;
        chk("bp_valid_drop", 64'(bv0), 64'd0);
        chk("bp_prod_ready_back", 64'(pr0), 64'd1);
        drain("drain_bp");

        // Resync: first flag mid-beam restarts the sum and latches sync_err.
        sb.push_back('{35'd17, 1'b0, 33'd17, 1'b0, 35'd2});
        send(32'd1, 1'b1); send(32'd2, 1'b0); send(32'd3, 1'b0);
        send(32'd10, 1'b1);
        for (int k = 0; k < 7; k++) send(32'd1, 1'b0);
        drain("drain_resync");
        chk("sync_err_set", 64'({se0, se1, se2}), 64'(3'b111));
        e = '{35'd8, 1'b0, 33'd8, 1'b0, 35'd1};
        sb.push_back(e);
        for (int k = 0; k < 8; k++) send(32'd1, k == 0);
        drain("drain_after_resync");
        chk("sync_err_sticky", 64'({se0, se1, se2}), 64'(3'b111));

        // Reset mid-beam: partial sum dropped, everything cleared.
        for (int k = 0; k < 3; k++) send(32'd100, k == 0);
        rst_n = 1'b0;
        #1;
        chk("midrst_prod_ready", 64'({pr0, pr1, pr2}), 64'd0);
        @(posedge clk); #1;
        chk("midrst_outputs", 64'({bv0, bo0, se0, se1, se2, bd0}), 64'd0);
        rst_n = 1'b1;
        sb.push_back('{35'd40, 1'b0, 33'd40, 1'b0, 35'd5});
        for (int k = 0; k < 8; k++) send(32'd5, 1'b0);
        drain("drain_midrst");
        chk("sync_err_after_rst", 64'({se0, se1, se2}), 64'd0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
